// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared 16-bit PCS word definitions and running-disparity rule
// Shared by the RX sync monitor and the TX disparity tracker so both directions
// apply exactly the same per-byte disparity step.
// No ports (package).
package phy_rx_pkg;

    typedef enum logic [1:0] {
        LOSS,
        ACQ,
        SYNC
    } rx_state_e;

    localparam logic [7:0]  K28_5      = 8'hBC;

    // Disparity-flip tables, indexed MSB-first (entry 0 is the leftmost bit).
    localparam logic [31:0] DP6_TABLE  = 32'b11101000100000011000000110010111;
    localparam logic [7:0]  DP4_TABLE  = 8'b10001001;

    // The twelve legal K code values.
    function automatic logic f_is_valid_k(input logic [7:0] d);
        logic hit;
        case (d)
            8'h1C, 8'h3C, 8'h5C, 8'h7C,
            8'h9C, 8'hBC, 8'hDC, 8'hFC,
            8'hF7, 8'hFB, 8'hFD, 8'hFE: hit = 1'b1;
            default:                    hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic f_rd_step8(input logic rd, input logic k, input logic [7:0] d);
        logic dp6;
        logic dp4;
        logic rd_n;
        dp6 = DP6_TABLE[5'd31 - d[4:0]];
        dp4 = DP4_TABLE[3'd7 - d[7:5]];
        // K codes other than K28.x keep the current disparity.
        if (k && (d[1:0] != 2'b00)) begin
            rd_n = rd;
        end else begin
            rd_n = rd ^ (k ^ dp6 ^ dp4);
        end
        return rd_n;
    endfunction

    // Upper byte is on the wire first, so it is applied first.
    function automatic logic f_rd_step16(input logic rd, input logic [1:0] k, input logic [15:0] d);
        logic rd_hi;
        rd_hi = f_rd_step8(rd, k[1], d[15:8]);
        return f_rd_step8(rd_hi, k[0], d[7:0]);
    endfunction

endpackage

// File: rtl/phy_rx_word_classify.sv
// rtl/phy_rx_word_classify.sv - combinational good/bad/aligned-comma decode of one RX word
// Ports:
//   data_i    [15:0] decoded word, [15:8] first on the wire
//   k_i       [1:0]  K flags, bit 1 for [15:8], bit 0 for [7:0]
//   enc_err_i        PHY code/disparity violation
//   bad_o            word is bad
//   comma_o          word is a good, aligned K28.5 comma
module phy_rx_word_classify
    import phy_rx_pkg::*;
(
    input  logic [15:0] data_i,
    input  logic [1:0]  k_i,
    input  logic        enc_err_i,
    output logic        bad_o,
    output logic        comma_o
);

    logic hi_k_bad;
    logic lo_k_bad;
    logic lo_comma;
    logic aligned;

    assign hi_k_bad = k_i[1] && !f_is_valid_k(data_i[15:8]);
    assign lo_k_bad = k_i[0] && !f_is_valid_k(data_i[7:0]);
    // A comma in the second byte means word alignment has slipped.
    assign lo_comma = k_i[0] && (data_i[7:0] == K28_5);
    assign aligned  = k_i[1] && !k_i[0] && (data_i[15:8] == K28_5);

    assign bad_o    = enc_err_i || hi_k_bad || lo_k_bad || lo_comma;
    assign comma_o  = aligned && !bad_o;

endmodule

// File: rtl/phy_rx_sync_monitor.sv
// rtl/phy_rx_sync_monitor.sv - RX word sync acquisition, disparity tracking and error statistics
// Ports:
//   clk_rx_i, rst_i        RX word clock, synchronous active-high reset
//   rx_data_i, rx_k_i      decoded word and K flags (one word per clock)
//   rx_enc_err_i           PHY code/disparity violation for this word
//   clr_cnt_i              synchronous clear of err/loss counters
//   synced_o               state is SYNC
//   comma_o                pulse: aligned comma accepted
//   rd_o                   running disparity after the last word (0 = RD-)
//   err_cnt_o, loss_cnt_o  saturating bad-word / sync-loss counters
module phy_rx_sync_monitor
    import phy_rx_pkg::*;
#(
    parameter int g_err_cnt_width  = 16,
    parameter int g_loss_cnt_width = 8,
    parameter int g_acq_commas     = 3
) (
    input  logic                        clk_rx_i,
    input  logic                        rst_i,
    input  logic [15:0]                 rx_data_i,
    input  logic [1:0]                  rx_k_i,
    input  logic                        rx_enc_err_i,
    input  logic                        clr_cnt_i,
    output logic                        synced_o,
    output logic                        comma_o,
    output logic                        rd_o,
    output logic [g_err_cnt_width-1:0]  err_cnt_o,
    output logic [g_loss_cnt_width-1:0] loss_cnt_o
);

    localparam logic [2:0] ACQ_N = 3'(g_acq_commas);
    localparam logic [g_err_cnt_width-1:0]  ERR_ONE  = {{(g_err_cnt_width-1){1'b0}}, 1'b1};
    localparam logic [g_loss_cnt_width-1:0] LOSS_ONE = {{(g_loss_cnt_width-1){1'b0}}, 1'b1};

    rx_state_e                   state_q;
    logic [2:0]                  comma_cnt_q;
    logic [1:0]                  bad_cnt_q;
    logic [1:0]                  good_cnt_q;
    logic                        synced_q;
    logic                        comma_q;
    logic                        rd_q;
    logic [g_err_cnt_width-1:0]  err_cnt_q;
    logic [g_loss_cnt_width-1:0] loss_cnt_q;

    logic                        w_bad;
    logic                        w_comma;
    logic                        err_inc;
    logic                        loss_inc;
    logic                        rd_d;
    logic [g_err_cnt_width-1:0]  err_cnt_d;
    logic [g_loss_cnt_width-1:0] loss_cnt_d;

    phy_rx_word_classify u_classify (
        .data_i    (rx_data_i),
        .k_i       (rx_k_i),
        .enc_err_i (rx_enc_err_i),
        .bad_o     (w_bad),
        .comma_o   (w_comma)
    );

    always_comb begin
        // Disparity is meaningless until a comma has framed the stream.
        rd_d     = (state_q == LOSS) ? 1'b0 : f_rd_step16(rd_q, rx_k_i, rx_data_i);
        err_inc  = (state_q == SYNC) && w_bad;
        loss_inc = err_inc && (bad_cnt_q == 2'd3);

        err_cnt_d = err_cnt_q;
        if (clr_cnt_i) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end

        loss_cnt_d = loss_cnt_q;
        if (clr_cnt_i) begin
            loss_cnt_d = '0;
        end else if (loss_inc && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + LOSS_ONE;
        end
    end

    always_ff @(posedge clk_rx_i) begin
        if (rst_i) begin
            state_q     <= LOSS;
            comma_cnt_q <= '0;
            bad_cnt_q   <= '0;
            good_cnt_q  <= '0;
            synced_q    <= 1'b0;
            comma_q     <= 1'b0;
            rd_q        <= 1'b0;
            err_cnt_q   <= '0;
            loss_cnt_q  <= '0;
        end else begin
            comma_q    <= w_comma;
            rd_q       <= rd_d;
            err_cnt_q  <= err_cnt_d;
            loss_cnt_q <= loss_cnt_d;

            unique case (state_q)
                LOSS: begin
                    if (w_comma) begin
                        if (ACQ_N == 3'd1) begin
                            state_q    <= SYNC;
                            synced_q   <= 1'b1;
                            bad_cnt_q  <= '0;
                            good_cnt_q <= '0;
                        end else begin
                            state_q     <= ACQ;
                            comma_cnt_q <= 3'd1;
                        end
                    end
                end
                ACQ: begin
                    if (w_bad) begin
                        state_q     <= LOSS;
                        comma_cnt_q <= '0;
                    end else if (w_comma) begin
                        if (comma_cnt_q + 3'd1 == ACQ_N) begin
                            state_q     <= SYNC;
                            synced_q    <= 1'b1;
                            comma_cnt_q <= '0;
                            bad_cnt_q   <= '0;
                            good_cnt_q  <= '0;
                        end else begin
                            comma_cnt_q <= comma_cnt_q + 3'd1;
                        end
                    end
                end
                SYNC: begin
                    if (w_bad) begin
                        good_cnt_q <= '0;
                        if (bad_cnt_q == 2'd3) begin
                            state_q     <= LOSS;
                            synced_q    <= 1'b0;
                            comma_cnt_q <= '0;
                            bad_cnt_q   <= '0;
                        end else begin
                            bad_cnt_q <= bad_cnt_q + 2'd1;
                        end
                    end else if (bad_cnt_q != 2'd0) begin
                        // Four clean words in a row forgive one earlier bad word.
                        if (good_cnt_q == 2'd3) begin
                            bad_cnt_q  <= bad_cnt_q - 2'd1;
                            good_cnt_q <= '0;
                        end else begin
                            good_cnt_q <= good_cnt_q + 2'd1;
                        end
                    end
                end
                default: begin
                    state_q  <= LOSS;
                    synced_q <= 1'b0;
                end
            endcase
        end
    end

    assign synced_o   = synced_q;
    assign comma_o    = comma_q;
    assign rd_o       = rd_q;
    assign err_cnt_o  = err_cnt_q;
    assign loss_cnt_o = loss_cnt_q;

endmodule
